mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 38 +++
 rtl/mult_div_unit.sv | 152 +++++++++++++++
 tb/tb_mult_div_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_pkg.sv
// Shared pipeline constants for the HI/LO multiply/divide unit.
// Holds the hilo_op and hilo_sel encodings and the default latencies.
// The E-stage decoder and the mult/div unit both import it, so the two
// always agree on the encodings.
package mult_div_unit_pkg;

  localparam int MULT_LAT_DEFAULT = 5;
  localparam int DIV_LAT_DEFAULT  = 10;

  typedef enum logic [2:0] {
    HILO_NONE  = 3'd0,
    HILO_MULT  = 3'd1,
    HILO_MULTU = 3'd2,
    HILO_DIV   = 3'd3,
    HILO_DIVU  = 3'd4,
    HILO_MTHI  = 3'd5,
    HILO_MTLO  = 3'd6,
    HILO_NOP   = 3'd7
  } hilo_op_e;

  typedef enum logic [1:0] {
    SEL_ZERO  = 2'd0,
    SEL_HI    = 2'd1,
    SEL_LO    = 2'd2,
    SEL_ZERO3 = 2'd3
  } hilo_sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  // Only mult/multu/div/divu occupy the unit for several cycles.
  function automatic logic is_launch_op(input logic [2:0] op);
    return (op >= 3'd1) && (op <= 3'd4);
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit.
// The result is computed combinationally at the launch edge and parked in
// temp_hi/temp_lo. A down-counter then models the fixed pipeline latency.
// The result is committed to HI/LO on the last busy edge.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   start     launch strobe for mult/multu/div/divu
//   hilo_op   op code (see hilo_op_e)
//   a, b      rs / rt operands
//   hilo_sel  read select: 1 HI, 2 LO, other values read zero
//   busy      registered; high while an op is in flight
//   rdata     combinational read of committed HI/LO
//   state_dbg current FSM state, for observation only
//
// Handshake: a launch is accepted only on an edge where start=1, hilo_op is
// 1..4 and busy=0. busy then stays high for exactly MULT_LAT/DIV_LAT cycles.
// The first cycle with busy=0 shows the new HI/LO. Requests seen while busy
// are dropped, not queued.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEFAULT,
  parameter int DIV_LAT  = DIV_LAT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  hilo_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [1:0]  hilo_sel,
  output logic        busy,
  output logic [31:0] rdata,
  output md_state_e   state_dbg
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_LAT);

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi, lo;
  logic [31:0]      temp_hi, temp_lo;
  logic             commit_en;

  // Combinational arithmetic feeding the temp registers
  logic signed [63:0] s_prod;
  logic        [63:0] u_prod;
  logic        [31:0] divisor;
  logic               b_zero;
  logic               s_ovf;
  logic signed [31:0] s_quo, s_rem;
  logic        [31:0] u_quo, u_rem;
  logic        [31:0] next_hi, next_lo;
  logic [CNT_W-1:0]   next_cnt;
  logic               next_commit;

  always_comb begin
    s_prod  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    u_prod  = {32'd0, a} * {32'd0, b};
    b_zero  = (b == 32'd0);
    // A zero divisor is replaced by 1 so the divider never sees x.
    // Its result is discarded at commit.
    divisor = b_zero ? 32'd1 : b;
    // Handle the most-negative / -1 case explicitly so the wrapped
    // result does not depend on how the tool treats the overflow.
    s_ovf   = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    s_quo   = s_ovf ? 32'sh8000_0000 : ($signed(a) / $signed(divisor));
    s_rem   = s_ovf ? 32'sh0 : ($signed(a) % $signed(divisor));
    u_quo   = a / divisor;
    u_rem   = a % divisor;

    next_hi     = 32'd0;
    next_lo     = 32'd0;
    next_cnt    = CNT_MULT;
    next_commit = 1'b1;
    case (hilo_op)
      HILO_MULT:  begin next_hi = s_prod[63:32]; next_lo = s_prod[31:0]; end
      HILO_MULTU: begin next_hi = u_prod[63:32]; next_lo = u_prod[31:0]; end
      HILO_DIV: begin
        next_hi     = s_rem;
        next_lo     = s_quo;
        next_cnt    = CNT_DIV;
        next_commit = !b_zero;
      end
      HILO_DIVU: begin
        next_hi     = u_rem;
        next_lo     = u_quo;
        next_cnt    = CNT_DIV;
        next_commit = !b_zero;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      hi        <= 32'd0;
      lo        <= 32'd0;
      temp_hi   <= 32'd0;
      temp_lo   <= 32'd0;
      commit_en <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start && is_launch_op(hilo_op)) begin
            temp_hi   <= next_hi;
            temp_lo   <= next_lo;
            cnt       <= next_cnt;
            commit_en <= next_commit;
            busy      <= 1'b1;
            state     <= ST_RUN;
          end else if (hilo_op == HILO_MTHI) begin
            hi <= a;
          end else if (hilo_op == HILO_MTLO) begin
            lo <= a;
          end
        end
        ST_RUN: begin
          cnt <= cnt - CNT_ONE;
          if (cnt == CNT_ONE) begin
            if (commit_en) begin
              hi <= temp_hi;
              lo <= temp_lo;
            end
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    case (hilo_sel)
      SEL_HI:  rdata = hi;
      SEL_LO:  rdata = lo;
      default: rdata = 32'd0;
    endcase
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: directed vectors with hand-computed results.
// Reads push the expected value into exp_q. The monitor pops and compares
// at the falling edge while a read is presented.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  hilo_op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [1:0]  hilo_sel = 2'd0;
  logic        busy;
  logic [31:0] rdata;
  md_state_e   state_dbg;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .hilo_op(hilo_op),
    .a(a), .b(b), .hilo_sel(hilo_sel), .busy(busy), .rdata(rdata),
    .state_dbg(state_dbg)
  );

  int tests = 0;
  int fails = 0;

  // scoreboard
  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        chk_valid = 1'b0;

  function automatic void check_val(input string name, input logic [31:0] act,
                                    input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endfunction

  // monitor
  always @(negedge clk) begin
    if (chk_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL monitor: rdata 0x%08h with empty expected queue", rdata);
      end else begin
        check_val(name_q.pop_front(), rdata, exp_q.pop_front());
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read(input logic [1:0] sel, input logic [31:0] exp, input string name);
    hilo_sel = sel;
    exp_q.push_back(exp);
    name_q.push_back(name);
    chk_valid = 1'b1;
    @(negedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic write_hilo(input logic [2:0] op, input logic [31:0] val);
    hilo_op = op;
    a = val;
    tick();
    hilo_op = 3'd0;
    a = 32'd0;
  endtask

  // Launch an op and count busy cycles. An optional second request
  // (inj_op) is driven during busy cycle inj_cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] oa, input logic [31:0] ob,
                        input int exp_len, input int inj_cycle, input logic [2:0] inj_op,
                        input logic [31:0] inj_a, input string name);
    int n;
    start = 1'b1;
    hilo_op = op;
    a = oa;
    b = ob;
    tick();
    start = 1'b0;
    hilo_op = 3'd0;
    a = 32'd0;
    b = 32'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == inj_cycle) begin
        start = is_launch_op(inj_op);
        hilo_op = inj_op;
        a = inj_a;
        b = inj_a;
      end
      tick();
      start = 1'b0;
      hilo_op = 3'd0;
      a = 32'd0;
      b = 32'd0;
    end
    check_val({name, " busy_len"}, 32'(n), 32'(exp_len));
  endtask

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen_busy;

    // reset state
    repeat (2) tick();
    reset = 1'b0;
    check_val("reset busy", 32'(busy), 32'd0);
    read(2'd1, 32'h0, "reset HI");
    read(2'd2, 32'h0, "reset LO");

    // mthi/mtlo and read selects
    write_hilo(3'd5, 32'h1234_5678);
    read(2'd1, 32'h1234_5678, "mthi HI");
    write_hilo(3'd6, 32'hCAFE_BABE);
    read(2'd2, 32'hCAFE_BABE, "mtlo LO");
    read(2'd0, 32'h0, "sel0 zero");
    read(2'd3, 32'h0, "sel3 zero");

    // op 7 and start with op 0 must not launch or touch HI/LO
    start = 1'b1; hilo_op = 3'd7; a = 32'h5555_5555; b = 32'd3;
    tick();
    check_val("op7 busy", 32'(busy), 32'd0);
    hilo_op = 3'd0;
    tick();
    check_val("op0 busy", 32'(busy), 32'd0);
    start = 1'b0; a = 32'd0; b = 32'd0;
    read(2'd1, 32'h1234_5678, "op7 HI");
    read(2'd2, 32'hCAFE_BABE, "op7 LO");

    // mult -2 * 3
    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, 5, 0, 3'd0, 32'd0, "mult");
    read(2'd1, 32'hFFFF_FFFF, "mult HI");
    read(2'd2, 32'hFFFF_FFFA, "mult LO");

    // multu max * max
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 0, 3'd0, 32'd0, "multu");
    read(2'd1, 32'hFFFF_FFFE, "multu HI");
    read(2'd2, 32'h0000_0001, "multu LO");

    // div -7 / 2
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, 10, 0, 3'd0, 32'd0, "div");
    read(2'd1, 32'hFFFF_FFFF, "div HI");
    read(2'd2, 32'hFFFF_FFFD, "div LO");

    // divu 7 / 0 with mtlo issued mid-busy: HI/LO untouched
    run_op(3'd4, 32'd7, 32'd0, 10, 3, 3'd6, 32'hDEAD_BEEF, "divu0");
    read(2'd1, 32'hFFFF_FFFF, "divu0 HI");
    read(2'd2, 32'hFFFF_FFFD, "divu0 LO");

    // signed overflow case
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 0, 3'd0, 32'd0, "divovf");
    read(2'd1, 32'h0000_0000, "divovf HI");
    read(2'd2, 32'h8000_0000, "divovf LO");

    // divu 0xFFFFFFF0 / 7 = 0x24924922 rem 2
    run_op(3'd4, 32'hFFFF_FFF0, 32'd7, 10, 0, 3'd0, 32'd0, "divu");
    read(2'd1, 32'h0000_0002, "divu HI");
    read(2'd2, 32'h2492_4922, "divu LO");

    // div 7 / -2 = -3 rem 1
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, 10, 0, 3'd0, 32'd0, "divneg");
    read(2'd1, 32'h0000_0001, "divneg HI");
    read(2'd2, 32'hFFFF_FFFD, "divneg LO");

    // second start during busy is ignored (mult 6*7, then 100*100)
    run_op(3'd1, 32'd6, 32'd7, 5, 2, 3'd1, 32'd100, "mult2nd");
    read(2'd1, 32'h0, "mult2nd HI");
    read(2'd2, 32'd42, "mult2nd LO");

    // div -100 / 7 = -14 rem -2, with 5/5 restart attempt
    run_op(3'd3, 32'hFFFF_FF9C, 32'd7, 10, 2, 3'd3, 32'd5, "div2nd");
    read(2'd1, 32'hFFFF_FFFE, "div2nd HI");
    read(2'd2, 32'hFFFF_FFF2, "div2nd LO");

    // reset during busy cycle 4 aborts the div
    start = 1'b1; hilo_op = 3'd3; a = 32'd100; b = 32'd7;
    tick();
    start = 1'b0; hilo_op = 3'd0; a = 32'd0; b = 32'd0;
    n = 0;
    while (busy && n < 3) begin
      n++;
      tick();
    end
    check_val("rst busy before", 32'(busy), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_val("rst busy after", 32'(busy), 32'd0);
    read(2'd1, 32'h0, "rst HI");
    read(2'd2, 32'h0, "rst LO");
    seen_busy = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (busy) seen_busy = 1'b1;
    end
    check_val("rst no busy", 32'(seen_busy), 32'd0);
    read(2'd1, 32'h0, "rst late HI");
    read(2'd2, 32'h0, "rst late LO");

    @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL scoreboard: %0d expected values never checked", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
